// File: rtl/dec_lut_gate.sv
// Programmable N_IN-input gate: one-hot decode of in_data picks one bit of a
// 2^N_IN-entry truth table that can be reloaded serially. Optional readback under CFG_READBACK_EN.
module dec_lut_gate #(
   parameter int N_IN       = 2,
   parameter int RESET_MODE = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cfg_start,
   input  logic                 cfg_bit,
   input  logic                 cfg_bit_vld,
   output logic                 cfg_busy,
   output logic                 cfg_done,
`ifdef CFG_READBACK_EN
   output logic                 cfg_rd_bit,
`endif
   input  logic                 in_vld,
   input  logic [N_IN-1:0]      in_data,
   output logic                 in_rdy,
   output logic [(1<<N_IN)-1:0] onehot_o,
   output logic                 out_vld,
   output logic                 out_data
);

   localparam int D  = 1 << N_IN;
   localparam int CW = $clog2(D) + 1;

   function automatic logic [D-1:0] reset_tbl();
      logic [D-1:0] t;
      t = '0;
      for (int k = 0; k < D; k++) begin
         case (RESET_MODE)
            0:       t[k] = (k != D-1);
            1:       t[k] = (k == 0);
            2:       t[k] = (k == D-1);
            3:       t[k] = (k != 0);
            4:       t[k] = ^k;
            default: t[k] = 1'b0;
         endcase
      end
      return t;
   endfunction

   localparam logic [D-1:0] RST_TBL = reset_tbl();

   typedef enum logic {RUN, LOAD} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  cnt;
   logic [D-1:0]   shadow, shadow_nxt, tbl;
   logic           accept, last, xfer;
   logic [1:0]     vld_pipe;

   assign accept = (state == LOAD) && cfg_bit_vld;
   assign last   = accept && (cnt == CW'(D-1));
   assign xfer   = in_vld && in_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (cfg_start) state_nxt = LOAD;
         LOAD:    if (last)      state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      in_rdy   = (state == RUN);
      cfg_busy = (state == LOAD);
   end

   // Commit includes the bit arriving on the final edge, so merge it here.
   always_comb begin
      shadow_nxt = shadow;
      if (accept) shadow_nxt[cnt[CW-2:0]] = cfg_bit;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         shadow   <= '0;
         tbl      <= RST_TBL;
         cfg_done <= 1'b0;
      end else begin
         cfg_done <= last;
         if (state == RUN && cfg_start) begin
            cnt <= '0;
         end else if (accept) begin
            shadow <= shadow_nxt;
            cnt    <= cnt + CW'(1);
         end
         if (last) tbl <= shadow_nxt;
      end
   end

`ifdef CFG_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cfg_rd_bit <= 1'b0;
      else if (accept) cfg_rd_bit <= tbl[cnt[CW-2:0]];
   end
`endif

   // Stage 1 decodes, stage 2 evaluates against whatever table is active then.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         onehot_o <= '0;
         out_data <= 1'b0;
      end else begin
         vld_pipe <= {vld_pipe[0], xfer};
         onehot_o <= xfer ? ({{(D-1){1'b0}}, 1'b1} << in_data) : '0;
         if (vld_pipe[0]) out_data <= |(onehot_o & tbl);
      end
   end

   assign out_vld = vld_pipe[1];

endmodule

// File: tb/tb_dec_lut_gate.sv
// Directed bench for dec_lut_gate: default NAND instance with reloads,
// plus an N_IN=3 XOR instance.
module tb_dec_lut_gate;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic       cfg_start, cfg_bit, cfg_bit_vld, cfg_busy, cfg_done;
   logic       in_vld, in_rdy, out_vld, out_data;
   logic [1:0] in_data;
   logic [3:0] a_onehot;

   logic       zero;
   logic       b_in_vld, b_in_rdy, b_out_vld, b_out_data, b_busy, b_done;
   logic [2:0] b_in_data;
   logic [7:0] b_onehot;
`ifdef CFG_READBACK_EN
   logic       a_rd, b_rd;
`endif

   dec_lut_gate #(.N_IN(2), .RESET_MODE(0)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(cfg_start), .cfg_bit(cfg_bit), .cfg_bit_vld(cfg_bit_vld),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done),
`ifdef CFG_READBACK_EN
      .cfg_rd_bit(a_rd),
`endif
      .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
      .onehot_o(a_onehot), .out_vld(out_vld), .out_data(out_data)
   );

   dec_lut_gate #(.N_IN(3), .RESET_MODE(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .cfg_start(zero), .cfg_bit(zero), .cfg_bit_vld(zero),
      .cfg_busy(b_busy), .cfg_done(b_done),
`ifdef CFG_READBACK_EN
      .cfg_rd_bit(b_rd),
`endif
      .in_vld(b_in_vld), .in_data(b_in_data), .in_rdy(b_in_rdy),
      .onehot_o(b_onehot), .out_vld(b_out_vld), .out_data(b_out_data)
   );

   typedef struct {
      logic [2:0] din;
      logic [7:0] oh;
      logic       q;
   } vec_t;

   vec_t vecs[20];
   int   nvec = 0;
   int   nerr = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Back-to-back transfers of vecs[s..s+n-1]; onehot one edge later, result two.
   task automatic pipe(input int s, input int n, input bit use_b);
      logic [7:0] oh;
      for (int c = 0; c < n + 2; c++) begin
         if (use_b) begin
            b_in_vld = (c < n);
            if (c < n) b_in_data = vecs[s+c].din;
         end else begin
            in_vld = (c < n);
            if (c < n) in_data = vecs[s+c].din[1:0];
         end
         tick();
         oh = use_b ? b_onehot : {4'b0, a_onehot};
         check("onehot", oh, (c < n) ? vecs[s+c].oh : 8'h0);
         if (c >= 1 && c <= n) begin
            check("out_vld", {7'b0, use_b ? b_out_vld : out_vld}, 8'h1);
            check("out_data", {7'b0, use_b ? b_out_data : out_data}, {7'b0, vecs[s+c-1].q});
         end else begin
            check("out_vld idle", {7'b0, use_b ? b_out_vld : out_vld}, 8'h0);
         end
      end
      check("out_data hold", {7'b0, use_b ? b_out_data : out_data}, {7'b0, vecs[s+n-1].q});
   endtask

   // Start coincides with a junk bit (must be ignored); in_vld held high during LOAD.
   task automatic load(input logic [3:0] bits, input bit gaps, input logic [3:0] old_tbl);
      cfg_start = 1'b1; cfg_bit_vld = 1'b1; cfg_bit = ~bits[0]; in_vld = 1'b0;
      tick();
      cfg_start = 1'b0; cfg_bit_vld = 1'b0; in_vld = 1'b1; in_data = 2'd2;
      check("busy after start", {7'b0, cfg_busy}, 8'h1);
      check("in_rdy in load", {7'b0, in_rdy}, 8'h0);
      for (int i = 0; i < 4; i++) begin
         if (gaps && i > 0) begin
            cfg_bit_vld = 1'b0; cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            check("busy in gap", {7'b0, cfg_busy}, 8'h1);
            check("done in gap", {7'b0, cfg_done}, 8'h0);
         end
         cfg_bit_vld = 1'b1; cfg_bit = bits[i];
         if (i == 3) in_vld = 1'b1;
         tick();
         cfg_bit_vld = 1'b0;
`ifdef CFG_READBACK_EN
         check("cfg_rd_bit", {7'b0, a_rd}, {7'b0, old_tbl[i]});
`else
         if (old_tbl[i] === 1'bx) check("old_tbl", 8'h0, 8'h1);
`endif
         check("onehot in load", {4'b0, a_onehot}, 8'h0);
         if (i < 3) begin
            check("busy mid", {7'b0, cfg_busy}, 8'h1);
            check("done mid", {7'b0, cfg_done}, 8'h0);
            check("in_rdy mid", {7'b0, in_rdy}, 8'h0);
         end else begin
            in_vld = 1'b0;
            check("done pulse", {7'b0, cfg_done}, 8'h1);
            check("busy end", {7'b0, cfg_busy}, 8'h0);
            check("in_rdy at done", {7'b0, in_rdy}, 8'h1);
         end
      end
      tick();
      check("done one cycle", {7'b0, cfg_done}, 8'h0);
   endtask

   initial begin
      // NAND, N_IN=2
      vecs[0]  = '{3'd0, 8'h01, 1'b1};
      vecs[1]  = '{3'd1, 8'h02, 1'b1};
      vecs[2]  = '{3'd2, 8'h04, 1'b1};
      vecs[3]  = '{3'd3, 8'h08, 1'b0};
      // XOR reload
      vecs[4]  = '{3'd0, 8'h01, 1'b0};
      vecs[5]  = '{3'd1, 8'h02, 1'b1};
      vecs[6]  = '{3'd2, 8'h04, 1'b1};
      vecs[7]  = '{3'd3, 8'h08, 1'b0};
      // NOR reload
      vecs[8]  = '{3'd0, 8'h01, 1'b1};
      vecs[9]  = '{3'd3, 8'h08, 1'b0};
      // NAND after reset aborts a load
      vecs[10] = '{3'd3, 8'h08, 1'b0};
      vecs[11] = '{3'd0, 8'h01, 1'b1};
      // N_IN=3 odd parity
      vecs[12] = '{3'd0, 8'h01, 1'b0};
      vecs[13] = '{3'd1, 8'h02, 1'b1};
      vecs[14] = '{3'd2, 8'h04, 1'b1};
      vecs[15] = '{3'd3, 8'h08, 1'b0};
      vecs[16] = '{3'd4, 8'h10, 1'b1};
      vecs[17] = '{3'd5, 8'h20, 1'b0};
      vecs[18] = '{3'd6, 8'h40, 1'b0};
      vecs[19] = '{3'd7, 8'h80, 1'b1};

      zero = 1'b0;
      rst_n = 1'b0;
      cfg_start = 1'b0; cfg_bit = 1'b0; cfg_bit_vld = 1'b0;
      in_vld = 1'b0; in_data = '0;
      b_in_vld = 1'b0; b_in_data = '0;
      #12;
      check("rst onehot", {4'b0, a_onehot}, 8'h0);
      check("rst out_vld", {7'b0, out_vld}, 8'h0);
      check("rst out_data", {7'b0, out_data}, 8'h0);
      check("rst busy", {7'b0, cfg_busy}, 8'h0);
      check("rst done", {7'b0, cfg_done}, 8'h0);
      check("rst in_rdy", {7'b0, in_rdy}, 8'h1);
`ifdef CFG_READBACK_EN
      check("rst rd_bit", {7'b0, a_rd}, 8'h0);
`endif
      @(negedge clk); rst_n = 1'b1;
      tick();

      pipe(0, 4, 1'b0);
      load(4'b0110, 1'b0, 4'b0111);
      pipe(4, 4, 1'b0);
      load(4'b0001, 1'b1, 4'b0110);
      pipe(8, 2, 1'b0);

      // Reset during LOAD after two bits
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0; cfg_bit_vld = 1'b1; cfg_bit = 1'b1;
      tick();
      tick();
      cfg_bit_vld = 1'b0;
      check("busy before abort", {7'b0, cfg_busy}, 8'h1);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", {7'b0, cfg_busy}, 8'h0);
      check("abort in_rdy", {7'b0, in_rdy}, 8'h1);
      check("abort done", {7'b0, cfg_done}, 8'h0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      pipe(10, 2, 1'b0);

      pipe(12, 8, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dec_lut_gate.md
Name: dec_lut_gate

Overview:
- Parametrised, programmable successor to the fixed decoder-built gates.
- An N_IN-input one-hot decoder selects one bit of a 2^N_IN-entry truth table. That bit is the gate output.
- The truth table resets to a selectable standard function (NAND by default). It can be reloaded at run time through a serial configuration port.
- Two-stage registered pipeline with a valid handshake. Used as the generic gate primitive inside the team's logic-function blocks.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..6. Table depth D = 2^N_IN.
- RESET_MODE, 0, truth table loaded at reset:
  - 0 = NAND
  - 1 = NOR
  - 2 = AND
  - 3 = OR
  - 4 = XOR (odd parity)
  - any other value = all-zero table

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cfg_start  input  1  request to begin a table reload
- cfg_bit  input  1  serial table bit
- cfg_bit_vld  input  1  cfg_bit valid this cycle
- cfg_busy  output  1  high while in LOAD
- cfg_done  output  1  one-cycle pulse when the new table is committed
- in_vld  input  1  in_data valid
- in_data  input  N_IN  gate inputs; in_data[N_IN-1] is the MSB of the decoder index
- in_rdy  output  1  block accepts in_data
- onehot_o  output  D  registered decoder output (stage 1)
- out_vld  output  1  out_data valid
- out_data  output  1  gate result (stage 2)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = RUN.
  - Active table = RESET_MODE pattern; shadow table = 0; bit counter = 0.
  - onehot_o=0, out_vld=0, out_data=0, cfg_busy=0, cfg_done=0.
  - Reset deasserts synchronously to clk. Reset asserted during LOAD discards the partial shadow load.
- Table indexing: entry k holds f(in_data==k).
  - NAND = all ones except entry D-1.
  - NOR = only entry 0 is one.
  - AND = only entry D-1 is one.
  - OR = all ones except entry 0.
  - XOR = entry k is one iff popcount(k) is odd.
- FSM states RUN and LOAD.
  - RUN to LOAD: cfg_start=1. Counter is cleared; cfg_busy rises the next cycle.
  - In LOAD, each cycle with cfg_bit_vld=1 writes cfg_bit into shadow[counter] and increments the counter. Bits are loaded entry 0 first.
  - LOAD to RUN: on the cycle the D-th bit is accepted. Shadow is copied to the active table on that edge, and cfg_done pulses one cycle.
  - cfg_start in LOAD is ignored. cfg_bit_vld in RUN is ignored.
  - cfg_start and cfg_bit_vld asserted together in RUN: the bit is ignored and the load begins on the next bit.
- Handshake:
  - in_rdy = (state==RUN). A transfer occurs when in_vld and in_rdy are both 1.
  - There is no output backpressure. The pipeline always advances.
- Pipeline:
  - Transfer at edge t: onehot_o = 1<<in_data valid after edge t.
  - out_data = OR-reduce(onehot_o AND active table), with out_vld=1, after edge t+1. Latency is 2 cycles, throughput 1 per cycle.
  - Without a transfer, onehot_o is 0 next cycle and out_vld is 0 after the following edge. out_data holds its last value while out_vld=0.
- Table swap: items already in stage 1 when the commit edge occurs use the new table. The stage-2 evaluation edge reads the active table. The first transfer after cfg_done is accepted the cycle cfg_done is high.
- Counter width is ceil(log2(D))+1; the counter never wraps during a load.

Optional Feature:
- Macro CFG_READBACK_EN.
- Defined:
  - Extra output cfg_rd_bit (1 bit), reset 0.
  - On every accepted cfg_bit in LOAD, cfg_rd_bit presents the old active-table entry at the same index on the next cycle. This allows serial readback of the previous table.
- Undefined: the port is absent and no readback logic is built.

Test Plan:
- Reset with defaults, apply in_data=0,1,2,3 back-to-back with in_vld=1 -> out_vld high 2 cycles after the first transfer; out_data=1,1,1,0; onehot_o=0001,0010,0100,1000.
- Pulse cfg_start, shift bits 0,1,1,0 (XOR) -> cfg_busy high for 4 loaded cycles, in_rdy=0 throughout; cfg_done pulses once; then in_data 0..3 -> out_data 0,1,1,0.
- Load with cfg_bit_vld gaps (e.g. 1,idle,0,idle,0,idle,0 = NOR) -> commit only after the 4th valid bit; in_data=0 -> 1, in_data=3 -> 0.
- Assert rst_n=0 after 2 of 4 bits in LOAD -> state RUN, cfg_busy=0, table reverts to NAND (in_data=3 -> 0).
- N_IN=3, RESET_MODE=4 -> in_data 0..7 give out_data 0,1,1,0,1,0,0,1.
- With CFG_READBACK_EN defined, reload after reset -> cfg_rd_bit streams 1,1,1,0 (the old NAND table).
